frame_write_packer: RTL and testbench
=====================================

Name: frame_write_packer

Overview:
- Write-side front end of the frame buffer, in the clk125 receive domain.
- Takes screen-packet payload bytes (rx_valid/rx_data), packs them into WORD_W-bit memory words and tags each word with a frame-relative word address.
- Presents words on a valid/ready stream to the DDR2 write path.
- Successor to the fixed 8-bit/RGB path: word width, bytes per pixel, frame size and output buffering are parametrised; adds frame bounding, tail flush and overflow detection.

Parameters:
- WORD_W, 64, output word width; multiple of 8, range 16..128.
- BPP_BYTES, 3, bytes per pixel (3 = RGB, 4 = RGBX).
- FRAME_PIXELS, 307200, pixels per frame (640x480).
- ADDR_W, 20, word-address width; must hold ceil(FRAME_PIXELS*BPP_BYTES/(WORD_W/8)).
- FIFO_DEPTH, 4, output buffer entries; power of two, at least 2.

Ports:
- clk125  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- new_frame  in  1  one-cycle pulse; arms or restarts frame capture.
- screen_packet  in  1  high while the current packet carries pixel payload.
- rx_valid  in  1  rx_data qualifier.
- rx_data  in  8  payload byte.
- wr_valid  out  1  output word available.
- wr_ready  in  1  consumer accepts the word.
- wr_data  out  WORD_W  packed word; first byte in bits [7:0].
- wr_addr  out  ADDR_W  word index within the frame.
- wr_last  out  1  final word of the frame.
- frame_done  out  1  one-cycle pulse when the last word enters the FIFO.
- overflow  out  1  sticky flag: a word was dropped; cleared by new_frame.
- busy  out  1  state is FILL.

Behaviour:
- Reset values: state IDLE; wr_valid, wr_last, frame_done, overflow and busy all 0; wr_data and wr_addr 0; all counters 0; FIFO empty.
- Byte accept: a byte is taken when screen_packet && rx_valid && state==FILL. In any other state the byte is ignored.
- States:
  - IDLE -> FILL on new_frame.
  - FILL -> DONE when byte number FRAME_PIXELS*BPP_BYTES-1 is accepted.
  - DONE -> FILL on new_frame.
  - new_frame in FILL restarts the frame and stays in FILL.
- new_frame effects: discard the partial word; zero the byte lane index and word address; clear overflow. Words already in the FIFO still drain.
- new_frame and an accepted byte in the same cycle: the byte becomes byte 0 of the new frame.
- Packing: lane index 0..WORD_W/8-1. When lane WORD_W/8-1 fills, the word is pushed on the next clock edge with the current address, then the address increments.
- Tail: when the frame's last byte fills a lane below the top, that word is pushed the same way with upper lanes zero-padded. wr_last is set on the frame's final word only. frame_done pulses in the push cycle.
- Latency: the last byte of a word accepted in cycle N gives wr_valid=1 in cycle N+1 if the FIFO was empty.
- FIFO: first-word-fall-through. wr_valid = not empty. An entry pops on wr_valid && wr_ready. wr_data, wr_addr and wr_last hold stable while wr_valid && !wr_ready.
- FIFO full: full is count==FIFO_DEPTH and no pop this cycle, so a push and a pop in the same cycle are both allowed when full.
- Push while full: the word is dropped and overflow is set. The address still advances so later words keep frame geometry. frame_done still pulses if the dropped word was the last.
- Address never wraps inside a frame; the only return to 0 is new_frame.
- reset mid-frame: everything returns to reset values immediately; FIFO contents are discarded.

Optional Feature:
- Macro FRAME_PACKER_STATS_EN.
- Defined: adds output drop_words[15:0] (words lost to FIFO full) and output stray_bytes[15:0] (rx_valid && screen_packet seen while not in FILL). Both are saturating at 16'hFFFF, reset to 0 and cleared by new_frame.
- Not defined: neither port exists and no counter logic is built.

Decomposition:
- Shared package frame_buffer_pkg:
  - state encoding ST_IDLE=0, ST_FILL=1, ST_DONE=2;
  - localparams BYTES_PER_WORD=WORD_W/8, FRAME_BYTES=FRAME_PIXELS*BPP_BYTES, FRAME_WORDS=ceil(FRAME_BYTES/BYTES_PER_WORD);
  - an output entry struct {data, addr, last}.
- One sub-module, packer_out_fifo: FWFT, parametrised width and depth, exposes count/full/empty. The packer FSM and lane logic stay in the top module.

Test Plan:
1. WORD_W=32, BPP_BYTES=3, FRAME_PIXELS=5; new_frame, then 15 bytes 0x01..0x0F with wr_ready=1 -> four words:
   - 0x04030201 @0
   - 0x08070605 @1
   - 0x0C0B0A09 @2
   - 0x000F0E0D @3 with wr_last=1
   - frame_done pulses once, state DONE.
2. Same configuration, wr_ready=0, FIFO_DEPTH=2, 15 bytes -> words 0 and 1 held; words 2 and 3 dropped; overflow=1; frame_done pulses; release wr_ready -> exactly addresses 0 and 1 are delivered.
3. new_frame after 6 bytes, then 15 bytes 0xA0.. -> the first completed word from before the restart (address 0) drains; the partial word is discarded; new words start at address 0 with first byte 0xA0; overflow=0.
4. Bytes sent in IDLE and DONE, and bytes with screen_packet=0 in FILL -> no words, no address change. With FRAME_PACKER_STATS_EN, stray_bytes equals the count sent in IDLE and DONE.
5. reset asserted mid-frame with 2 words queued -> wr_valid=0 immediately; after release the block stays IDLE and ignores bytes until new_frame.
6. Defaults (WORD_W=64, 640x480x3), continuous bytes, random wr_ready at 50% -> 115200 words, addresses 0..115199 in order, wr_last only on address 115199, overflow=0 when the byte rate is at most 1 per 2 cycles.

Source files
------------

// File: rtl/frame_buffer_pkg.sv
// Shared types and default frame geometry for the frame buffer write path.
// Modules derive their own geometry from parameters via ceil_div.
package frame_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    localparam int DEF_WORD_W       = 64;
    localparam int DEF_BPP_BYTES    = 3;
    localparam int DEF_FRAME_PIXELS = 307200;
    localparam int DEF_ADDR_W       = 20;

    localparam int BYTES_PER_WORD = DEF_WORD_W / 8;
    localparam int FRAME_BYTES    = DEF_FRAME_PIXELS * DEF_BPP_BYTES;
    localparam int FRAME_WORDS    = ceil_div(FRAME_BYTES, BYTES_PER_WORD);

    typedef struct packed {
        logic [DEF_WORD_W-1:0] data;
        logic [DEF_ADDR_W-1:0] addr;
        logic                  last;
    } out_entry_t;

endpackage

// File: rtl/packer_out_fifo.sv
// First-word-fall-through output buffer for packed frame words.
// Latency: a push is visible at the head on the next cycle when empty.
// Backpressure: full only when count==DEPTH with no pop; pushes while full are ignored.
module packer_out_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               pop_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign full    = (count_q == CNT_W'(DEPTH)) && !do_pop;
    assign do_push = push && !full;
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/frame_write_packer.sv
// Packs screen-packet payload bytes into addressed WORD_W words for the DDR2 write path.
// Latency: word-completing byte in cycle N gives wr_valid in N+1 (empty FIFO); FRAME_PACKER_STATS_EN adds drop/stray counters.
// Backpressure: wr_valid/wr_ready; a word arriving at a full FIFO is dropped and flags overflow.
module frame_write_packer
    import frame_buffer_pkg::*;
#(
    parameter int WORD_W       = 64,
    parameter int BPP_BYTES    = 3,
    parameter int FRAME_PIXELS = 307200,
    parameter int ADDR_W       = 20,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk125,
    input  logic              reset,
    input  logic              new_frame,
    input  logic              screen_packet,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [WORD_W-1:0] wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_last,
    output logic              frame_done,
    output logic              overflow,
    output logic              busy
`ifdef FRAME_PACKER_STATS_EN
    ,
    output logic [15:0]       drop_words,
    output logic [15:0]       stray_bytes
`endif
);
    localparam int BPW         = WORD_W / 8;
    localparam int FRAME_BYTES = FRAME_PIXELS * BPP_BYTES;
    localparam int LANE_W      = $clog2(BPW);
    localparam int CNT_W       = $clog2(FRAME_BYTES + 1);
    localparam int ENTRY_W     = WORD_W + ADDR_W + 1;
    localparam logic [LANE_W-1:0] TOP_LANE  = LANE_W'(BPW - 1);
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(FRAME_BYTES - 1);

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } entry_t;

    state_t            state_q, state_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [WORD_W-1:0] buf_q, buf_d, merged;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              overflow_q, overflow_d;
    logic              accept, last_byte, push;
    entry_t            push_entry, head;
    logic              fifo_full, fifo_empty;

    assign accept = screen_packet && rx_valid && (state_q == ST_FILL);

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        buf_d      = buf_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        merged     = '0;
        last_byte  = 1'b0;
        push       = 1'b0;
        push_entry = '0;
        frame_done = 1'b0;

        // A restart resets the frame first so a same-cycle byte lands as byte 0.
        if (new_frame) begin
            state_d    = ST_FILL;
            lane_d     = '0;
            buf_d      = '0;
            addr_d     = '0;
            cnt_d      = '0;
            overflow_d = 1'b0;
        end

        if (accept) begin
            merged                      = buf_d;
            merged[8*int'(lane_d) +: 8] = rx_data;
            last_byte                   = (cnt_d == LAST_BYTE);
            cnt_d                       = cnt_d + 1'b1;
            if (lane_d == TOP_LANE || last_byte) begin
                push            = 1'b1;
                push_entry.data = merged;
                push_entry.addr = addr_d;
                push_entry.last = last_byte;
                lane_d          = '0;
                buf_d           = '0;
                if (fifo_full) overflow_d = 1'b1;
                if (last_byte) begin
                    frame_done = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    addr_d = addr_d + 1'b1;
                end
            end else begin
                lane_d = lane_d + 1'b1;
                buf_d  = merged;
            end
        end
    end

    always_ff @(posedge clk125 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lane_q     <= '0;
            buf_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            buf_q      <= buf_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    packer_out_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk      (clk125),
        .rst      (reset),
        .push     (push),
        .push_dat (push_entry),
        .pop      (wr_valid && wr_ready),
        .pop_dat  (head),
        .count    (),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign wr_valid = !fifo_empty;
    assign wr_data  = head.data;
    assign wr_addr  = head.addr;
    assign wr_last  = head.last;
    assign overflow = overflow_q;
    assign busy     = (state_q == ST_FILL);

`ifdef FRAME_PACKER_STATS_EN
    logic [15:0] drop_q, drop_d, stray_q, stray_d;

    always_comb begin
        drop_d  = new_frame ? 16'd0 : drop_q;
        stray_d = new_frame ? 16'd0 : stray_q;
        if (push && fifo_full && drop_d != 16'hFFFF) drop_d = drop_d + 1'b1;
        if (screen_packet && rx_valid && state_q != ST_FILL && stray_d != 16'hFFFF)
            stray_d = stray_d + 1'b1;
    end

    always_ff @(posedge clk125 or posedge reset) begin
        if (reset) begin
            drop_q  <= '0;
            stray_q <= '0;
        end else begin
            drop_q  <= drop_d;
            stray_q <= stray_d;
        end
    end

    assign drop_words  = drop_q;
    assign stray_bytes = stray_q;
`endif

endmodule

// File: tb/tb_frame_write_packer.sv
// Randomised and directed bench for frame_write_packer: a small 32-bit/5-pixel instance
// for corner cases and a 64-bit/800-pixel instance for a full streamed frame.
module tb_frame_write_packer;

    typedef struct {
        logic [63:0] data;
        int          addr;
        bit          last;
    } ent_t;

    logic clk125 = 1'b0;
    always #4 clk125 = ~clk125;
    logic reset;

    logic        a_nf, a_sp, a_rv, a_rdy, a_wv, a_wl, a_fd, a_ov, a_busy;
    logic [7:0]  a_rd, a_wa;
    logic [31:0] a_wd;
    logic        b_nf, b_sp, b_rv, b_rdy, b_wv, b_wl, b_fd, b_ov, b_busy;
    logic [7:0]  b_rd;
    logic [63:0] b_wd;
    logic [19:0] b_wa;
`ifdef FRAME_PACKER_STATS_EN
    logic [15:0] a_drop, a_stray, b_drop, b_stray;
`endif

    frame_write_packer #(
        .WORD_W(32), .BPP_BYTES(3), .FRAME_PIXELS(5), .ADDR_W(8), .FIFO_DEPTH(2)
    ) dut_a (
        .clk125(clk125), .reset(reset), .new_frame(a_nf), .screen_packet(a_sp),
        .rx_valid(a_rv), .rx_data(a_rd), .wr_valid(a_wv), .wr_ready(a_rdy),
        .wr_data(a_wd), .wr_addr(a_wa), .wr_last(a_wl), .frame_done(a_fd),
        .overflow(a_ov), .busy(a_busy)
`ifdef FRAME_PACKER_STATS_EN
        , .drop_words(a_drop), .stray_bytes(a_stray)
`endif
    );

    frame_write_packer #(
        .WORD_W(64), .BPP_BYTES(3), .FRAME_PIXELS(800), .ADDR_W(20), .FIFO_DEPTH(4)
    ) dut_b (
        .clk125(clk125), .reset(reset), .new_frame(b_nf), .screen_packet(b_sp),
        .rx_valid(b_rv), .rx_data(b_rd), .wr_valid(b_wv), .wr_ready(b_rdy),
        .wr_data(b_wd), .wr_addr(b_wa), .wr_last(b_wl), .frame_done(b_fd),
        .overflow(b_ov), .busy(b_busy)
`ifdef FRAME_PACKER_STATS_EN
        , .drop_words(b_drop), .stray_bytes(b_stray)
`endif
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   fd_a = 0;
    int   fd_b = 0;
    bit   b_rand = 1'b0;
    ent_t got_a[$];
    ent_t got_b[$];
    ent_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accepted words seen on the output stream, plus frame_done pulses.
    always @(negedge clk125) begin
        if (!reset && a_wv && a_rdy) got_a.push_back('{data: 64'(a_wd), addr: int'(a_wa), last: a_wl});
        if (!reset && b_wv && b_rdy) got_b.push_back('{data: b_wd, addr: int'(b_wa), last: b_wl});
        if (a_fd) fd_a++;
        if (b_fd) fd_b++;
    end

    always begin
        @(posedge clk125);
        #1;
        if (b_rand) b_rdy = 1'($urandom_range(0, 1));
    end

    // Expected words for a frame's accepted bytes: complete words only, unless the
    // byte list is the whole frame, in which case the tail is zero padded and marked last.
    task automatic model_frame(input logic [7:0] fb[$], input int bpw, input int fbytes);
        int          nw;
        logic [63:0] d;
        bit          whole;
        whole = (fb.size() == fbytes);
        nw    = whole ? (fbytes + bpw - 1) / bpw : fb.size() / bpw;
        for (int w = 0; w < nw; w++) begin
            d = '0;
            for (int k = 0; k < bpw; k++)
                if (w * bpw + k < fb.size()) d[8*k +: 8] = fb[w*bpw+k];
            exp_q.push_back('{data: d, addr: w, last: whole && (w == nw - 1)});
        end
    endtask

    task automatic compare_words(input string tag, input ent_t got[$]);
        int n;
        check({tag, ".count"}, 64'(got.size()), 64'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d].data", tag, i), got[i].data, exp_q[i].data);
            check($sformatf("%s[%0d].addr", tag, i), 64'(got[i].addr), 64'(exp_q[i].addr));
            check($sformatf("%s[%0d].last", tag, i), 64'(got[i].last), 64'(exp_q[i].last));
        end
        exp_q.delete();
    endtask

    task automatic a_cycle(input logic nf, input logic sp, input logic v, input logic [7:0] d);
        a_nf = nf; a_sp = sp; a_rv = v; a_rd = d;
        @(posedge clk125);
        #1;
        a_nf = 1'b0; a_rv = 1'b0;
    endtask

    task automatic b_cycle(input logic nf, input logic sp, input logic v, input logic [7:0] d);
        b_nf = nf; b_sp = sp; b_rv = v; b_rd = d;
        @(posedge clk125);
        #1;
        b_nf = 1'b0; b_rv = 1'b0;
    endtask

    task automatic idle_a(input int n);
        repeat (n) a_cycle(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Sends bytes first..first+n-1 as an accepted run and records them into fb.
    task automatic a_run(input logic [7:0] first, input int n, output logic [7:0] fb[$]);
        fb.delete();
        for (int i = 0; i < n; i++) begin
            fb.push_back(first + 8'(i));
            a_cycle(1'b0, 1'b1, 1'b1, first + 8'(i));
        end
    endtask

    initial begin
        logic [7:0] fb[$];
        logic [7:0] fb2[$];
        logic [7:0] x;
        int         waited;

        reset = 1'b1;
        a_nf = 0; a_sp = 0; a_rv = 0; a_rd = 0; a_rdy = 0;
        b_nf = 0; b_sp = 0; b_rv = 0; b_rd = 0; b_rdy = 0;
        #2;
        check("rst.wr_valid", 64'(a_wv), 0);
        check("rst.wr_data", 64'(a_wd), 0);
        check("rst.wr_addr", 64'(a_wa), 0);
        check("rst.wr_last", 64'(a_wl), 0);
        check("rst.frame_done", 64'(a_fd), 0);
        check("rst.overflow", 64'(a_ov), 0);
        check("rst.busy", 64'(a_busy), 0);
        check("rst.b_wr_valid", 64'(b_wv), 0);
        @(posedge clk125);
        #1;
        reset = 1'b0;
        idle_a(2);

        // 1: one full frame, consumer always ready.
        a_rdy = 1'b1; got_a.delete(); fd_a = 0;
        a_cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("t1.busy", 64'(a_busy), 1);
        fb.delete();
        for (int i = 1; i <= 15; i++) begin
            fb.push_back(8'(i));
            a_cycle(1'b0, 1'b1, 1'b1, 8'(i));
            if (i == 3) check("t1.no_early_word", 64'(a_wv), 0);
            if (i == 4) check("t1.latency", 64'(a_wv), 1);
        end
        idle_a(4);
        model_frame(fb, 4, 15);
        compare_words("t1", got_a);
        check("t1.frame_done", 64'(fd_a), 1);
        check("t1.done_state", 64'(a_busy), 0);
        check("t1.overflow", 64'(a_ov), 0);

        // 2: consumer stalled, FIFO of two fills and later words drop.
        a_rdy = 1'b0; got_a.delete(); fd_a = 0;
        a_cycle(1'b1, 1'b0, 1'b0, 8'h00);
        a_run(8'h01, 15, fb);
        idle_a(2);
        check("t2.overflow", 64'(a_ov), 1);
        check("t2.frame_done", 64'(fd_a), 1);
        check("t2.head_valid", 64'(a_wv), 1);
        check("t2.head_data", 64'(a_wd), 64'h04030201);
        idle_a(3);
        check("t2.hold_addr", 64'(a_wa), 0);
        check("t2.hold_data", 64'(a_wd), 64'h04030201);
`ifdef FRAME_PACKER_STATS_EN
        check("t2.drop_words", 64'(a_drop), 2);
`endif
        a_rdy = 1'b1;
        idle_a(4);
        fb2 = fb[0:7];
        model_frame(fb2, 4, 15);
        compare_words("t2", got_a);

        // 3: restart mid-frame; the restart cycle also carries byte 0xA0.
        got_a.delete(); fd_a = 0;
        a_cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("t3.overflow_cleared", 64'(a_ov), 0);
        a_run(8'h11, 6, fb);
        model_frame(fb, 4, 15);
        a_cycle(1'b1, 1'b1, 1'b1, 8'hA0);
        a_run(8'hA1, 14, fb2);
        fb2.push_front(8'hA0);
        idle_a(4);
        model_frame(fb2, 4, 15);
        compare_words("t3", got_a);
        check("t3.overflow", 64'(a_ov), 0);
        check("t3.frame_done", 64'(fd_a), 1);

        // 4: bytes in DONE and with screen_packet low are ignored.
        got_a.delete();
        for (int i = 0; i < 4; i++) a_cycle(1'b0, 1'b1, 1'b1, 8'hEE);
        idle_a(2);
        check("t4.done_words", 64'(got_a.size()), 0);
        check("t4.done_busy", 64'(a_busy), 0);
`ifdef FRAME_PACKER_STATS_EN
        check("t4.stray_done", 64'(a_stray), 4);
`endif
        a_cycle(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) a_cycle(1'b0, 1'b0, 1'b1, 8'hDD);
        idle_a(2);
        check("t4.nosp_words", 64'(got_a.size()), 0);
        a_run(8'h31, 4, fb);
        idle_a(3);
        model_frame(fb, 4, 15);
        compare_words("t4", got_a);

        // 5: reset with two words queued.
        a_rdy = 1'b0;
        a_run(8'h41, 8, fb);
        idle_a(1);
        check("t5.queued", 64'(a_wv), 1);
        reset = 1'b1;
        #1;
        check("t5.async_valid", 64'(a_wv), 0);
        check("t5.async_busy", 64'(a_busy), 0);
        @(posedge clk125);
        #1;
        reset = 1'b0;
        a_rdy = 1'b1; got_a.delete(); fd_a = 0;
        for (int i = 0; i < 3; i++) a_cycle(1'b0, 1'b1, 1'b1, 8'h77);
        idle_a(2);
        check("t5.idle_words", 64'(got_a.size()), 0);
        check("t5.idle_busy", 64'(a_busy), 0);
        check("t5.overflow", 64'(a_ov), 0);
`ifdef FRAME_PACKER_STATS_EN
        check("t5.stray_idle", 64'(a_stray), 3);
`endif
        a_cycle(1'b1, 1'b0, 1'b0, 8'h00);
        a_run(8'h51, 15, fb);
        idle_a(4);
        model_frame(fb, 4, 15);
        compare_words("t5", got_a);
        check("t5.frame_done", 64'(fd_a), 1);

        // 6: 64-bit words, random payload at most one byte per two cycles, random ready.
        got_b.delete(); fd_b = 0; b_rand = 1'b1;
        b_cycle(1'b1, 1'b0, 1'b0, 8'h00);
        fb.delete();
        for (int i = 0; i < 2400; i++) begin
            x = 8'($urandom);
            fb.push_back(x);
            b_cycle(1'b0, 1'b1, 1'b1, x);
            repeat ($urandom_range(1, 2))
                b_cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        end
        waited = 0;
        while (got_b.size() < 300 && waited < 2000) begin
            @(posedge clk125);
            #1;
            waited++;
        end
        check("t6.drain_timeout", 64'(got_b.size() >= 300), 1);
        b_rand = 1'b0;
        model_frame(fb, 8, 2400);
        compare_words("t6", got_b);
        check("t6.overflow", 64'(b_ov), 0);
        check("t6.frame_done", 64'(fd_b), 1);
        check("t6.done_busy", 64'(b_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
